// File: rtl/delay_arbiter_pkg.sv
// Shared definitions for the delay arbiter: FSM state encoding and default sizing.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_W  = 32;
    localparam int unsigned DEF_IW = 2;

endpackage

// File: rtl/delay_arbiter_wrap_counter.sv
// W-bit up counter with synchronous clear, count enable and asynchronous reset.
module wrap_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear wins over enable; otherwise advance by one when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that lends one shared delay counter to N requesters.
// The owner gets grant for until+1 cycles, then a single-cycle done pulse.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned IW = DEF_IW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_until,
    output logic [N-1:0]   o_grant,
    output logic [N-1:0]   o_done,
    output logic           o_busy,
    output logic [IW-1:0]  o_owner,
    output logic [W-1:0]   o_count
);

    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    state_t        r_state;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_done;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_ptr;
    logic [W-1:0]  r_until_l;

    logic [W-1:0]  w_until_arr [N];
    logic [IW-1:0] w_pick;
    logic          w_owner_req;
    logic          w_terminal;
    logic          w_cnt_en;
    logic          w_cnt_clr;
    logic [W-1:0]  w_count;

    // First set request bit searching upward from p+1, wrapping at N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] win;
        logic [IW-1:0] sel;
        logic          found;
        int unsigned   idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(p) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && r[sel]) begin
                win   = sel;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Split the flat terminal-value bus into per-requester slices.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_until_arr[i] = i_until[i*W +: W];
        end
    end

    assign w_pick      = rr_pick(i_req, r_ptr);
    assign w_owner_req = i_req[r_owner];
    assign w_terminal  = (w_count == r_until_l);

    // The counter holds at the terminal value through DONE so it can never
    // run past all-ones; it is cleared outside COUNT and on abort.
    assign w_cnt_en  = (r_state == ST_COUNT) && w_owner_req && !w_terminal;
    assign w_cnt_clr = (r_state != ST_COUNT) || !w_owner_req;

    wrap_counter #(
        .W (W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_q   (w_count)
    );

    // Arbitration FSM with registered grant/done/owner outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_owner   <= '0;
            r_ptr     <= IW'(N - 1);
            r_until_l <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (i_req != '0) begin
                        r_owner   <= w_pick;
                        r_ptr     <= w_pick;
                        r_until_l <= w_until_arr[w_pick];
                        r_grant   <= ONE_HOT0 << w_pick;
                        r_state   <= ST_COUNT;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_COUNT: begin
                    // Abort is tested first so it beats a same-cycle terminal match.
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_terminal) begin
                        r_grant <= '0;
                        r_done  <= ONE_HOT0 << r_owner;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == ST_COUNT) || (r_state == ST_DONE);
    assign o_grant = r_grant;
    assign o_done  = r_done;
    assign o_owner = r_owner;
    assign o_count = w_count;

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter: drivers push expected grant/done/count
// beats, monitors pop and compare whenever the DUT shows grant or done.
module tb_delay_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] until_v;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   owner;
    logic [31:0]  count;

    logic [1:0]   req2;
    logic [7:0]   until2;
    logic [1:0]   grant2;
    logic [1:0]   done2;
    logic         busy2;
    logic [0:0]   owner2;
    logic [3:0]   count2;

    typedef struct {
        logic [3:0]  g;
        logic [3:0]  d;
        logic [31:0] c;
    } exp_t;

    exp_t sbq[$];
    exp_t q2[$];
    exp_t e_m;
    exp_t e_m2;

    int ntests = 0;
    int nfail  = 0;

    delay_arbiter #(.N(4), .W(32), .IW(2)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_until(until_v),
        .o_grant(grant), .o_done(done), .o_busy(busy), .o_owner(owner), .o_count(count)
    );

    delay_arbiter #(.N(2), .W(4), .IW(1)) dut2 (
        .clk(clk), .rst(rst), .i_req(req2), .i_until(until2),
        .o_grant(grant2), .o_done(done2), .o_busy(busy2), .o_owner(owner2), .o_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_job(input int k, input int unsigned u);
        exp_t e;
        for (int unsigned c = 0; c <= u; c++) begin
            e.g = 4'b0001 << k;
            e.d = 4'b0000;
            e.c = c;
            sbq.push_back(e);
        end
        e.g = 4'b0000;
        e.d = 4'b0001 << k;
        e.c = u;
        sbq.push_back(e);
    endtask

    // Monitor for the 4x32 instance.
    always @(negedge clk) begin
        if (!rst && (grant != 4'b0 || done != 4'b0)) begin
            if (sbq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_out: grant=%b done=%b count=%0h", grant, done, count);
            end else begin
                e_m = sbq.pop_front();
                check("grant", 32'(grant), 32'(e_m.g));
                check("done", 32'(done), 32'(e_m.d));
                check("count", count, e_m.c);
                check("busy", 32'(busy), 32'd1);
            end
        end
    end

    // Monitor for the 2x4 instance.
    always @(negedge clk) begin
        if (!rst && (grant2 != 2'b0 || done2 != 2'b0)) begin
            if (q2.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_out2: grant=%b done=%b count=%0h", grant2, done2, count2);
            end else begin
                e_m2 = q2.pop_front();
                check("grant2", 32'(grant2), 32'(e_m2.g));
                check("done2", 32'(done2), 32'(e_m2.d));
                check("count2", 32'(count2), e_m2.c);
            end
        end
    end

    // Single job on requester k: raise req, drop it on done, check latency.
    task automatic serve(input int k, input int unsigned u);
        int cyc;
        bit ok;
        @(negedge clk);
        #1;
        until_v[k*32 +: 32] = u;
        push_job(k, u);
        req[k] = 1'b1;
        cyc = 0;
        ok  = 0;
        while (!ok && cyc < int'(u) + 10) begin
            @(negedge clk);
            cyc++;
            if (done[k]) begin
                ok     = 1;
                req[k] = 1'b0;
            end
        end
        check("serve_latency", 32'(cyc), u + 32'd2);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_count", count, 32'd0);
    endtask

    // Multi-requester run: drop each req bit on its done, until all seen.
    task automatic run_until_all(input logic [3:0] want, input int bound, output int cyc);
        logic [3:0] seen;
        seen = 4'b0;
        cyc  = 0;
        while (seen != want && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (done != 4'b0) begin
                seen = seen | done;
                req  = req & ~done;
            end
        end
        check("all_done", 32'(seen), 32'(want));
    endtask

    initial begin
        int   cyc;
        bit   hit;
        exp_t e;

        rst     = 1'b1;
        req     = 4'b0;
        until_v = '0;
        req2    = 2'b0;
        until2  = '0;

        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_count", count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All four request at once after reset; until=1 each.
        @(negedge clk);
        #1;
        until_v = {32'd1, 32'd1, 32'd1, 32'd1};
        for (int k = 0; k < 4; k++) push_job(k, 1);
        req = 4'b1111;
        run_until_all(4'b1111, 100, cyc);
        check("rr_period", 32'(cyc), 32'd15);

        // Requester 0, until=3.
        serve(0, 3);
        // Requester 2, until=0.
        serve(2, 0);

        // Abort: requester 1 drops req while count==2 (until=5).
        @(negedge clk);
        #1;
        until_v[63:32] = 32'd5;
        for (int unsigned c = 0; c < 3; c++) begin
            e.g = 4'b0010;
            e.d = 4'b0000;
            e.c = c;
            sbq.push_back(e);
        end
        req[1] = 1'b1;
        cyc = 0;
        hit = 0;
        while (!hit && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (grant[1] && count == 32'd2) begin
                hit    = 1;
                req[1] = 1'b0;
            end
        end
        check("abort_reach", 32'(hit), 32'd1);
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", count, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        until_v[63:32] = 32'd1;
        until_v[95:64] = 32'd0;
        push_job(2, 0);
        push_job(1, 1);
        req = 4'b0110;
        run_until_all(4'b0110, 40, cyc);

        // Asynchronous reset while count==7.
        @(negedge clk);
        #1;
        until_v[31:0] = 32'd20;
        push_job(0, 20);
        req = 4'b0001;
        cyc = 0;
        hit = 0;
        while (!hit && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (count == 32'd7) hit = 1;
        end
        check("rst7_reach", 32'(hit), 32'd1);
        #2;
        sbq.delete();
        rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_owner", 32'(owner), 32'd0);
        check("arst_count", count, 32'd0);
        req = 4'b0;
        @(posedge clk);
        #1;
        until_v[31:0]  = 32'd2;
        until_v[63:32] = 32'd1;
        push_job(0, 2);
        push_job(1, 1);
        req = 4'b0011;
        rst = 1'b0;
        run_until_all(4'b0011, 40, cyc);

        // All-ones terminal on a 4-bit instance: count 0..F, then done, no wrap.
        @(negedge clk);
        #1;
        until2[3:0] = 4'hF;
        for (int unsigned c = 0; c <= 15; c++) begin
            e.g = 4'b0001;
            e.d = 4'b0000;
            e.c = c;
            q2.push_back(e);
        end
        e.g = 4'b0000;
        e.d = 4'b0001;
        e.c = 32'hF;
        q2.push_back(e);
        req2 = 2'b01;
        cyc = 0;
        hit = 0;
        while (!hit && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done2[0]) begin
                hit  = 1;
                req2 = 2'b00;
            end
        end
        check("max_latency", 32'(cyc), 32'd17);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        check("sb2_empty", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Shares one wrap-around cycle counter among N requesters that each need a programmable delay of `until + 1` cycles, e.g. multi-cycle unit stalls, bus wait states and the timer tick. Round-robin arbitration grants the counter to one requester at a time, loads that requester's terminal value, runs the count and returns a one-cycle `done` pulse to the owner. It sits between the CPU's multi-cycle control units and a single counter instance, replacing per-unit private counters.

## Interface
- `N`, default 4: number of requesters (2..8).
- `W`, default 32: counter and terminal-value width.
- `IW`, default 2: owner index width, equal to clog2(N).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester delay request, level.
- `until`  in  N*W  terminal values; slice i is `until[i*W +: W]`.
- `grant`  out  N  one-hot; the current counter owner.
- `done`  out  N  one-cycle pulse to the owner when its delay has expired.
- `busy`  out  1  high in COUNT and DONE.
- `owner`  out  IW  index of the last granted requester.
- `count`  out  W  live counter value.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE: if `req` is nonzero, pick the first set bit searching upward from `(ptr+1) mod N` with wrap. Latch the winner into `owner` and its `until` slice into `until_l`. Clear the counter, set `ptr` to the winner, go to COUNT.
- COUNT: `grant[owner]` is high and the counter increments by 1 each cycle starting at 0.
  - If `count == until_l`, go to DONE.
  - If `req[owner]` drops, abort: go to IDLE, clear the counter, and do not pulse `done`. Abort has priority over reaching the terminal value in the same cycle.
- DONE: `done[owner]` is high for exactly one cycle and `grant` is zero. Next state is IDLE.
- Requester rule: deassert `req` on the edge that samples `done`. A `req` still high in IDLE is treated as a new request.
- `until` is sampled only at grant. Changes during COUNT are ignored.
- Counter arithmetic is unsigned W-bit. `until_l = 2^W-1` is legal and the counter never overflows past it.
- `ptr` is updated only at grant, so an abort still advances round-robin fairness.

## Timing
- Reset values: state IDLE, `grant=0`, `done=0`, `busy=0`, `owner=0`, `count=0`. `ptr=N-1`, so requester 0 wins first.
- `grant` rises on the first edge after `req` is seen in IDLE, giving 1 cycle of arbitration latency.
- `grant` stays high for exactly `until_l + 1` cycles, with `count` = 0..`until_l`.
- `done` is high in the cycle after the last grant cycle.
- Back-to-back service has one IDLE cycle between grants. The per-request period is `until_l + 3` cycles.
- `rst` mid-operation clears all outputs immediately (asynchronous) and no `done` is issued.
- All outputs are registered except `busy`, which is decoded from the state.

## Structure
- A shared package holds the state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the default N/W constants.
- One sub-module, `wrap_counter`, provides a W-bit counter with a synchronous clear, an enable and an async `rst`. The arbiter/FSM drives it.
- The round-robin pick is a function inside `delay_arbiter`, not a separate module.

## Test plan
- Single requester, `req=4'b0001`, `until[0]=3` → `grant=0001` for 4 cycles with `count` 0,1,2,3, then `done=0001` for 1 cycle, then IDLE.
- `until=0` on requester 2 → `grant=0100` for 1 cycle, then `done=0100`.
- Simultaneous `req=4'b1111` after reset, all `until=1`, each requester dropping `req` on its `done` → grants in order 0,1,2,3, each lasting 2 cycles, with 1 idle cycle between them.
- Requester 1 drops `req` when `count=2` with `until=5` → `grant` clears the next cycle, no `done` pulse, and the next request is granted to requester 2 before requester 1.
- Assert `rst` when `count=7` → all outputs 0 immediately. After release with `req=0001`, requester 0 is granted.
- `until[0]=32'hFFFF_FFFF` with forced counter preload → `count` reaches FFFF_FFFF, then `done`, with no wrap to 0 while granted.
